// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider family: FSM state encoding and
// width defaults.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    // Counter must hold 0..WIDTH-1; keep at least one bit for degenerate widths.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_w(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step_cell.sv
// One restoring-division iteration: shift in a dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module div_step_cell
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] dvs_ext;

    // The incoming remainder is always below the divisor, so its MSB never
    // contributes to the trial value.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    assign trial    = {rem[WIDTH-1:0], dvd_bit};
    assign dvs_ext  = {1'b0, divisor};
    assign q_bit    = (trial >= dvs_ext);
    assign rem_next = q_bit ? (trial - dvs_ext) : trial;

endmodule

// File: rtl/seq_divider8.sv
// Iterative restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module seq_divider8
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2*WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     quotient_o,
    output logic [WIDTH-1:0]     remainder_o,
    output logic                 div0_o,
    output logic                 ovf_o
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]     dvs_q;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     quo_q;

    logic                 accept;
    logic                 op_div0;
    logic                 op_ovf;
    logic                 last_iter;
    logic [WIDTH:0]       rem_next;
    logic                 q_bit;

    assign accept    = in_valid_i && in_ready_o;
    assign op_div0   = (divisor_i == '0);
    // A high half not below the divisor means the quotient needs > WIDTH bits.
    assign op_ovf    = !op_div0 && (dividend_i[2*WIDTH-1:WIDTH] >= divisor_i);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    div_step_cell #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_bit  (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (op_div0 || op_ovf) ? DONE : CALC;
            CALC: if (last_iter) state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div0_o      <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    dvd_q <= dividend_i;
                    dvs_q <= divisor_i;
                    cnt_q <= '0;
                    quo_q <= '0;
                    rem_q <= '0;
                    if (op_div0 || op_ovf) begin
                        quotient_o  <= '1;
                        remainder_o <= dividend_i[WIDTH-1:0];
                        div0_o      <= op_div0;
                        ovf_o       <= op_ovf;
                    end else begin
                        rem_q <= {1'b0, dividend_i[2*WIDTH-1:WIDTH]};
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    dvd_q <= dvd_q << 1;
                    quo_q <= {quo_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        quotient_o  <= {quo_q[WIDTH-2:0], q_bit};
                        remainder_o <= rem_next[WIDTH-1:0];
                        div0_o      <= 1'b0;
                        ovf_o       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider8.sv
// Directed bench for seq_divider8: vector table plus backpressure/busy and
// mid-operation reset sequences.
module tb_seq_divider8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div0;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        d0;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    seq_divider8 #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .div0_o      (div0),
        .ovf_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Waits for out_valid, returning the number of edges after the accepting edge.
    task automatic wait_valid(input string nm, output int k);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no out_valid expected out_valid within 40 cycles", nm);
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int k;
        @(negedge clk);
        check({nm, "_in_ready"}, 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        dividend = v.dvd;
        divisor  = v.dvs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(nm, k);
        check({nm, "_latency"}, 16'(k), 16'(v.lat));
        check({nm, "_quotient"}, 16'(quotient), 16'(v.q));
        check({nm, "_remainder"}, 16'(remainder), 16'(v.r));
        check({nm, "_flags"}, 16'({div0, ovf}), 16'({v.d0, v.ov}));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, "_valid_drop"}, 16'({out_valid, in_ready}), 16'b01);
        out_ready = 1'b0;
    endtask

    initial begin
        int k;
        int seen;

        vecs[0] = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 8};
        vecs[1] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 8};
        vecs[2] = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 0};
        vecs[3] = '{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 0};
        vecs[4] = '{16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 8};
        vecs[5] = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 8};
        vecs[6] = '{16'hABCD, 8'hAB, 8'hFF, 8'hCD, 1'b0, 1'b1, 0};
        vecs[7] = '{16'h1000, 8'h20, 8'h80, 8'h00, 1'b0, 1'b0, 8};
        vecs[8] = '{16'h00FF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 8};
        vecs[9] = '{16'h00C8, 8'h0D, 8'h0F, 8'h05, 1'b0, 1'b0, 8};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("reset_ready_valid", 16'({in_ready, out_valid}), 16'b10);
        check("reset_q_r", {quotient, remainder}, 16'h0000);
        check("reset_flags", 16'({div0, ovf}), 16'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure and busy: operands offered while busy must be ignored.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'h0064;
        divisor  = 8'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("busy_calc_ready", 16'(in_ready), 16'd0);
        in_valid = 1'b1;
        dividend = 16'hFFFF;
        divisor  = 8'h01;
        @(posedge clk); #1;
        wait_valid("busy", k);
        check("busy_latency", 16'(k), 16'd7);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d_q_r", c), {quotient, remainder}, 16'h0E02);
            check($sformatf("hold%0d_vld_rdy", c), 16'({out_valid, in_ready, div0, ovf}), 16'b1000);
            @(posedge clk); #1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("busy_release", 16'({out_valid, in_ready}), 16'b01);
        out_ready = 1'b0;
        run_vec("after_busy", '{16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 8});

        // Asynchronous reset in the 4th CALC cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'h0064;
        divisor  = 8'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_ready_valid", 16'({in_ready, out_valid}), 16'b10);
        check("midrst_q_r", {quotient, remainder}, 16'h0000);
        check("midrst_flags", 16'({div0, ovf}), 16'b00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_valid", 16'(seen), 16'd0);
        run_vec("after_rst", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
